ro_puf_ctrl: RTL and testbench
==============================

RO_PUF_CTRL -- requirements
Module: ro_puf_ctrl

Interface
REQ-001 Parameter NBITS, default 8, response bits generated per run (1..16).
REQ-002 Parameter SETTLE, default 4, cycles with ring pair disabled after each reconfiguration.
REQ-003 Parameter WINDOW, default 1024, measurement cycles per bit with ring pair enabled.
REQ-004 Parameter CW, default 16, edge-counter width.
REQ-005 clk  in  1  single system clock; all state on rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 start  in  1  one-cycle request to begin a run; sampled only in IDLE.
REQ-008 challenge  in  6  [2:0] base select, [5:3] bypass pattern; captured on accepted start.
REQ-009 ro_sel  out  3  select lines to the ring-oscillator pair.
REQ-010 ro_bx  out  3  bypass lines to the ring-oscillator pair.
REQ-011 ro_en  out  1  enable to the ring-oscillator pair.
REQ-012 ro_out1, ro_out2  in  1 each  asynchronous oscillator outputs.
REQ-013 busy  out  1  high from accepted start until done.
REQ-014 done  out  1  one-cycle pulse when response is complete.
REQ-015 response  out  NBITS  result; held stable from done until next accepted start.

Function
REQ-016 FSM states IDLE, SETTLE, MEASURE, COMPARE, FINISH; encoding free.
REQ-017 IDLE: start=1 captures challenge, clears response and bit index i to 0, enters SETTLE next cycle; start while not IDLE is ignored.
REQ-018 Per bit i: ro_sel = challenge[2:0] XOR i[2:0], ro_bx = challenge[5:3]; both registered and stable for all of SETTLE and MEASURE.
REQ-019 SETTLE: ro_en=0, both edge counters cleared, exactly SETTLE cycles, then MEASURE.
REQ-020 MEASURE: ro_en=1 for exactly WINDOW cycles, then COMPARE; ro_en low in every other state.
REQ-021 Each ro_outN passes a 2-flop synchronizer then a rising-edge detector; each detected edge increments its counter by 1.
REQ-022 Counters saturate at 2^CW-1; no wrap-around.
REQ-023 Edge detector history reset to current synchronized value on SETTLE entry so no spurious edge is counted from prior configuration.
REQ-024 COMPARE (1 cycle): response[i] = 1 iff cnt1 > cnt2; tie (incl. both saturated or both zero) yields 0.
REQ-025 After COMPARE: if i = NBITS-1 go FINISH, else i increments and SETTLE re-entered.
REQ-026 FINISH (1 cycle): done=1, busy=0 thereafter, return to IDLE.
REQ-027 Run latency start-to-done = 1 + NBITS*(SETTLE+WINDOW+1) + 1 cycles.
REQ-028 start coincident with done is ignored (FSM not yet IDLE).

Reset
REQ-029 rst=1 forces IDLE next edge from any state; mid-run partial response is discarded.
REQ-030 Reset values: ro_en=0, ro_sel=0, ro_bx=0, busy=0, done=0, response=0, counters=0, i=0, synchronizers=0.
REQ-031 rst has priority over start in the same cycle.

Verification
REQ-032 NBITS=8,SETTLE=4,WINDOW=64; challenge=6'b101_011; ro_out1 period 4 clk, ro_out2 period 6 -> response=8'hFF, done at cycle 1+8*69+1=554 after start.
REQ-033 Same, ro_out1 period 6, ro_out2 period 4 -> response=8'h00; ro_sel observed per bit 3,2,1,0,7,6,5,4; ro_bx=3'b101 throughout.
REQ-034 Both outputs identical period 4 -> every bit tie -> response=8'h00.
REQ-035 CW=4, both outputs period 2 clk, WINDOW=64 -> both counters saturate at 15 -> response=0; no counter wraps.
REQ-036 rst asserted in MEASURE of bit 3 -> next cycle ro_en=0, busy=0, response=0; new start runs full length normally.
REQ-037 start pulsed during busy and on done cycle -> ignored; only one done per accepted start.

Source files
------------

// File: rtl/ro_puf_ctrl.sv
// ro_puf_ctrl: ring-oscillator PUF controller; races a selected RO pair once per
// response bit and records which ring produced more edges in a fixed window.
module ro_puf_ctrl #(
    parameter int NBITS  = 8,
    parameter int SETTLE = 4,
    parameter int WINDOW = 1024,
    parameter int CW     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [5:0]       challenge,
    output logic [2:0]       ro_sel,
    output logic [2:0]       ro_bx,
    output logic             ro_en,
    input  logic             ro_out1,
    input  logic             ro_out2,
    output logic             busy,
    output logic             done,
    output logic [NBITS-1:0] response
);
    localparam int PW = $clog2(SETTLE + WINDOW + 1);
    localparam int IW = NBITS > 1 ? $clog2(NBITS) : 1;

    typedef enum logic [2:0] {IDLE, SETL, MEAS, CMP, FIN} state_t;

    state_t        state;
    logic [PW-1:0] pc;
    logic [IW-1:0] i;
    logic [2:0]    base;
    logic [1:0]    sy1, sy2;
    logic          h1, h2;
    logic [CW-1:0] c1, c2;
    logic          e1, e2;

    assign e1 = sy1[1] & ~h1;
    assign e2 = sy2[1] & ~h2;

    // History always tracks the synchronized value, so it is current on SETTLE entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            sy1 <= '0;
            sy2 <= '0;
            h1  <= 1'b0;
            h2  <= 1'b0;
            c1  <= '0;
            c2  <= '0;
        end else begin
            sy1 <= {sy1[0], ro_out1};
            sy2 <= {sy2[0], ro_out2};
            h1  <= sy1[1];
            h2  <= sy2[1];
            c1  <= state == SETL ? '0 : (ro_en && e1 && ~&c1) ? c1 + 1'b1 : c1;
            c2  <= state == SETL ? '0 : (ro_en && e2 && ~&c2) ? c2 + 1'b1 : c2;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            pc       <= '0;
            i        <= '0;
            base     <= '0;
            ro_sel   <= '0;
            ro_bx    <= '0;
            ro_en    <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            response <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    base     <= challenge[2:0];
                    ro_sel   <= challenge[2:0];
                    ro_bx    <= challenge[5:3];
                    response <= '0;
                    i        <= '0;
                    pc       <= '0;
                    busy     <= 1'b1;
                    state    <= SETL;
                end
                SETL: if (pc == PW'(SETTLE - 1)) begin
                    pc    <= '0;
                    ro_en <= 1'b1;
                    state <= MEAS;
                end else begin
                    pc <= pc + 1'b1;
                end
                MEAS: if (pc == PW'(WINDOW - 1)) begin
                    pc    <= '0;
                    ro_en <= 1'b0;
                    state <= CMP;
                end else begin
                    pc <= pc + 1'b1;
                end
                CMP: begin
                    response[i] <= c1 > c2;
                    if (i == IW'(NBITS - 1)) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= FIN;
                    end else begin
                        i      <= i + 1'b1;
                        ro_sel <= base ^ 3'(i + 1'b1);
                        state  <= SETL;
                    end
                end
                FIN: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ro_puf_ctrl.sv
// tb_ro_puf_ctrl: scoreboard bench; bench oscillators run at a period chosen per
// ro_sel, and the model predicts each bit from saturated edge counts W/period.
module tb_ro_puf_ctrl;
    localparam int N = 8, S = 4, W = 64, CW = 4;
    localparam int LAT = 1 + N * (S + W + 1) + 1;

    logic         clk = 0, rst = 1, start = 0;
    logic [5:0]   challenge = '0;
    logic [2:0]   ro_sel, ro_bx;
    logic         ro_en, busy, done;
    logic         ro_out1 = 0, ro_out2 = 0;
    logic [N-1:0] response;

    int ncmp = 0, nfail = 0, cyc = 0, mbit = 0;
    logic pen = 0;
    int p1[8] = '{default: 4};
    int p2[8] = '{default: 4};

    typedef struct {
        logic [N-1:0] resp;
        logic [5:0]   chal;
        int           st;
    } item_t;
    item_t q[$];

    ro_puf_ctrl #(.NBITS(N), .SETTLE(S), .WINDOW(W), .CW(CW)) dut (
        .clk(clk), .rst(rst), .start(start), .challenge(challenge),
        .ro_sel(ro_sel), .ro_bx(ro_bx), .ro_en(ro_en),
        .ro_out1(ro_out1), .ro_out2(ro_out2),
        .busy(busy), .done(done), .response(response)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Oscillators share one time base, so equal periods give identical waveforms.
    always @(posedge clk) begin
        #2;
        ro_out1 = (cyc % p1[ro_sel]) < p1[ro_sel] / 2;
        ro_out2 = (cyc % p2[ro_sel]) < p2[ro_sel] / 2;
    end

    function automatic int sat_cnt(int p);
        int c = W / p;
        return c > (1 << CW) - 1 ? (1 << CW) - 1 : c;
    endfunction

    function automatic logic [N-1:0] model(logic [5:0] ch);
        logic [N-1:0] r = '0;
        for (int b = 0; b < N; b++) begin
            logic [2:0] sel = ch[2:0] ^ 3'(b);
            r[b] = sat_cnt(p1[sel]) > sat_cnt(p2[sel]);
        end
        return r;
    endfunction

    task automatic chk(string nm, int act, int exp);
        ncmp++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic set_tab(int a, int b);
        for (int k = 0; k < 8; k++) begin
            p1[k] = a;
            p2[k] = b;
        end
    endtask

    task automatic run(logic [5:0] ch, bit spam);
        bit hit = 0;
        @(posedge clk); #1;
        challenge = ch;
        start = 1;
        q.push_back('{model(ch), ch, cyc});
        for (int k = 0; k < LAT + 50 && !hit; k++) begin
            @(posedge clk); #1;
            if (spam) challenge = 6'($urandom);
            if (done) begin
                start = spam;
                hit = 1;
            end else begin
                start = spam && ($urandom_range(0, 15) == 0);
            end
        end
        @(posedge clk); #1;
        start = 0;
        chk("done_seen", int'(hit), 1);
        repeat (3) @(posedge clk);
    endtask

    always @(negedge clk) begin
        if (rst) begin
            mbit = 0;
            pen = 0;
        end else begin
            if (ro_en) begin
                if (q.size() == 0) chk("ro_en_without_run", 1, 0);
                else begin
                    chk("ro_sel", ro_sel, q[0].chal[2:0] ^ 3'(mbit));
                    chk("ro_bx", ro_bx, q[0].chal[5:3]);
                end
            end
            if (pen && !ro_en) mbit++;
            pen = ro_en;
            if (done) begin
                if (q.size() == 0) chk("spurious_done", 1, 0);
                else begin
                    item_t it;
                    it = q.pop_front();
                    chk("response", response, it.resp);
                    chk("latency", cyc - it.st + 1, LAT);
                    chk("bits_measured", mbit, N);
                    chk("busy_at_done", busy, 0);
                end
                mbit = 0;
            end
        end
    end

    initial begin
        bit found = 0;
        repeat (3) @(posedge clk); #1;
        chk("rst_ro_en", ro_en, 0);
        chk("rst_ro_sel", ro_sel, 0);
        chk("rst_ro_bx", ro_bx, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_response", response, 0);
        rst = 0;

        set_tab(4, 6);  run(6'b101_011, 0);
        set_tab(6, 4);  run(6'b101_011, 0);
        set_tab(4, 4);  run(6'b101_011, 0);
        set_tab(2, 2);  run(6'b010_110, 0);
        set_tab(2, 4);  run(6'b111_000, 0);
        set_tab(4, 10); run(6'b001_101, 0);

        // Abort in bit 3 of a run that would otherwise produce all ones.
        set_tab(4, 6);
        @(posedge clk); #1;
        challenge = 6'b011_001;
        start = 1;
        q.push_back('{model(6'b011_001), 6'b011_001, cyc});
        @(posedge clk); #1;
        start = 0;
        for (int k = 0; k < 2 * LAT && !found; k++) begin
            @(posedge clk); #1;
            found = ro_en && mbit == 3;
        end
        chk("reached_bit3", int'(found), 1);
        chk("partial_response", response, 7);
        rst = 1;
        q.delete();
        @(posedge clk); #1;
        chk("abort_ro_en", ro_en, 0);
        chk("abort_busy", busy, 0);
        chk("abort_response", response, 0);
        rst = 0;
        repeat (2) @(posedge clk);
        run(6'b011_001, 0);

        for (int r = 0; r < 7; r++) begin
            for (int k = 0; k < 8; k++) begin
                p1[k] = 2 * $urandom_range(1, 5);
                p2[k] = 2 * $urandom_range(1, 5);
            end
            run(6'($urandom), r < 2);
        end
        chk("queue_drained", q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule
